// File: rtl/layer_compositor.sv
// Per-pixel layer compositor: frame-synchronous enables and blinking, then a
// two-stage pipeline that picks the highest-priority visible layer.
module layer_compositor #(
    parameter int NUM_LAYERS   = 6,
    parameter int ADDR_W       = 17,
    parameter int BLINK_FRAMES = 16,
    localparam int SEL_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [9:0]                   h_cnt,
    input  logic [9:0]                   v_cnt,
    input  logic [NUM_LAYERS-1:0]        layer_hit,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS-1:0]        blink_mask,
    output logic [ADDR_W-1:0]            pixel_addr,
    output logic                         notBlank,
    output logic [SEL_W-1:0]             layer_sel,
    output logic                         blink_phase
);

    localparam int FCNT_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    logic                         w_fsNow;
    logic                         w_frameTick;
    logic                         r_fsD;
    logic [NUM_LAYERS-1:0]        r_enQ;
    logic [NUM_LAYERS-1:0]        r_blinkQ;
    logic [FCNT_W-1:0]            r_fcnt;
    logic                         r_blinkPhase;
    logic [NUM_LAYERS-1:0]        w_vis;
    logic [NUM_LAYERS-1:0]        r_vis;
    logic [NUM_LAYERS*ADDR_W-1:0] r_addr;
    logic                         w_found;
    logic [SEL_W-1:0]             w_selIdx;
    logic [ADDR_W-1:0]            w_selAddr;
    logic [ADDR_W-1:0]            r_pixelAddr;
    logic                         r_notBlank;
    logic [SEL_W-1:0]             r_layerSel;

    // Edge-detect frame start so counters held at 0 for many clocks give one tick.
    assign w_fsNow     = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign w_frameTick = w_fsNow && !r_fsD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsD        <= 1'b0;
            r_enQ        <= '1;
            r_blinkQ     <= '0;
            r_fcnt       <= '0;
            r_blinkPhase <= 1'b1;
        end else begin
            r_fsD <= w_fsNow;
            if (w_frameTick) begin
                r_enQ    <= layer_en;
                r_blinkQ <= blink_mask;
                if (r_fcnt == FCNT_LAST) begin
                    r_fcnt       <= '0;
                    r_blinkPhase <= ~r_blinkPhase;
                end else begin
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end
            end
        end
    end

    assign w_vis = layer_hit & r_enQ & (~r_blinkQ | {NUM_LAYERS{r_blinkPhase}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vis <= '0;
        end else begin
            r_vis <= w_vis;
        end
    end

    // Addresses are only meaningful alongside r_vis, so they need no reset.
    always_ff @(posedge clk) begin
        r_addr <= layer_addr;
    end

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        w_found   = 1'b0;
        w_selIdx  = '0;
        w_selAddr = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_vis[i]) begin
                w_found   = 1'b1;
                w_selIdx  = SEL_W'(i);
                w_selAddr = r_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixelAddr <= '0;
            r_notBlank  <= 1'b0;
            r_layerSel  <= '0;
        end else begin
            r_pixelAddr <= w_selAddr;
            r_notBlank  <= w_found;
            r_layerSel  <= w_selIdx;
        end
    end

    assign pixel_addr  = r_pixelAddr;
    assign notBlank    = r_notBlank;
    assign layer_sel   = r_layerSel;
    assign blink_phase = r_blinkPhase;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: stimulus pushes hand-computed
// expectations into a scoreboard that a negedge monitor drains 2 clocks later.
module tb_layer_compositor;

    localparam int NL = 6;
    localparam int AW = 17;
    localparam int SW = 3;

    localparam logic [AW-1:0] A0 = 17'h00AA0;
    localparam logic [AW-1:0] A1 = 17'h00BB1;
    localparam logic [AW-1:0] A2 = 17'h00123;
    localparam logic [AW-1:0] A3 = 17'h00DD3;
    localparam logic [AW-1:0] A4 = 17'h00EE4;
    localparam logic [AW-1:0] A5 = 17'h1FFF5;
    localparam logic [NL-1:0] ALL = 6'b111111;
    localparam logic [NL-1:0] NO2 = 6'b111011;

    logic             clk = 1'b0;
    logic             rst;
    logic [9:0]       hCnt;
    logic [9:0]       vCnt;
    logic [NL-1:0]    layerHit;
    logic [NL*AW-1:0] layerAddr;
    logic [NL-1:0]    layerEn;
    logic [NL-1:0]    blinkMask;
    logic [AW-1:0]    pixelAddr;
    logic             notBlank;
    logic [SW-1:0]    layerSel;
    logic             blinkPhase;

    typedef struct {
        int            due;
        bit            check;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic          nb;
        string         name;
    } exp_t;

    exp_t sbq[$];
    int   cycleCnt = 0;
    int   nChecks  = 0;
    int   nFails   = 0;

    layer_compositor #(
        .NUM_LAYERS  (NL),
        .ADDR_W      (AW),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (hCnt),
        .v_cnt      (vCnt),
        .layer_hit  (layerHit),
        .layer_addr (layerAddr),
        .layer_en   (layerEn),
        .blink_mask (blinkMask),
        .pixel_addr (pixelAddr),
        .notBlank   (notBlank),
        .layer_sel  (layerSel),
        .blink_phase(blinkPhase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; its result is due two rising edges later.
    task automatic applyStimulus(input logic r, input logic [NL-1:0] hit, input logic [NL-1:0] en,
                                 input logic [NL-1:0] mask, input logic [9:0] h, input logic [9:0] v,
                                 input logic [AW-1:0] eAddr, input logic [SW-1:0] eSel, input logic eNb,
                                 input bit chk, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        layerHit  = hit;
        layerEn   = en;
        blinkMask = mask;
        hCnt      = h;
        vCnt      = v;
        e.due   = cycleCnt + 2;
        e.check = chk;
        e.addr  = eAddr;
        e.sel   = eSel;
        e.nb    = eNb;
        e.name  = name;
        sbq.push_back(e);
    endtask

    // Monitor: compare every scoreboard entry that has come due.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cycleCnt) begin
            e = sbq.pop_front();
            if (e.check) begin
                if (e.due != cycleCnt) begin
                    checkOutput({e.name, ".late"}, 32'(cycleCnt), 32'(e.due));
                end else begin
                    checkOutput({e.name, ".addr"}, 32'(pixelAddr), 32'(e.addr));
                    checkOutput({e.name, ".sel"},  32'(layerSel),  32'(e.sel));
                    checkOutput({e.name, ".nb"},   32'(notBlank),  32'(e.nb));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pending;
        rst       = 1'b1;
        hCnt      = 10'd5;
        vCnt      = 10'd7;
        layerHit  = '0;
        layerEn   = ALL;
        blinkMask = '0;
        layerAddr = {A5, A4, A3, A2, A1, A0};

        repeat (3) applyStimulus(1'b1, 6'b000001, ALL, 6'b0, 10'd5, 10'd7, '0, '0, 1'b0, 1'b0, "reset");
        checkOutput("reset_addr",  32'(pixelAddr),  32'd0);
        checkOutput("reset_sel",   32'(layerSel),   32'd0);
        checkOutput("reset_nb",    32'(notBlank),   32'd0);
        checkOutput("reset_phase", 32'(blinkPhase), 32'd1);

        // After reset all layers are enabled until the first frame start.
        applyStimulus(1'b0, 6'b000000, ALL, 6'b0, 10'd5, 10'd7, '0, 3'd0, 1'b0, 1'b1, "post_rst_blank");
        applyStimulus(1'b0, 6'b100000, NO2, 6'b0, 10'd6, 10'd7, A5, 3'd5, 1'b1, 1'b1, "post_rst_l5");
        applyStimulus(1'b0, 6'b000100, NO2, 6'b0, 10'd7, 10'd7, A2, 3'd2, 1'b1, 1'b1, "post_rst_en_all");

        // Tick 1 (fcnt 0->1), then priority selection.
        applyStimulus(1'b0, 6'b000000, ALL, 6'b0, 10'd0, 10'd0, '0, 3'd0, 1'b0, 1'b1, "tick1_blank");
        applyStimulus(1'b0, 6'b101100, ALL, 6'b0, 10'd1, 10'd0, A2, 3'd2, 1'b1, 1'b1, "prio_101100");
        applyStimulus(1'b0, 6'b100000, ALL, 6'b0, 10'd2, 10'd0, A5, 3'd5, 1'b1, 1'b1, "prio_l5");
        applyStimulus(1'b0, 6'b000001, ALL, 6'b0, 10'd3, 10'd0, A0, 3'd0, 1'b1, 1'b1, "prio_l0");
        applyStimulus(1'b0, 6'b111111, ALL, 6'b0, 10'd4, 10'd0, A0, 3'd0, 1'b1, 1'b1, "prio_all");
        applyStimulus(1'b0, 6'b110000, ALL, 6'b0, 10'd5, 10'd0, A4, 3'd4, 1'b1, 1'b1, "prio_110000");
        applyStimulus(1'b0, 6'b000000, ALL, 6'b0, 10'd6, 10'd0, '0, 3'd0, 1'b0, 1'b1, "blank");
        applyStimulus(1'b0, 6'b000010, ALL, 6'b0, 10'd7, 10'd0, A1, 3'd1, 1'b1, 1'b1, "prio_l1");

        // Mid-frame disable of layer 2 is ignored until tick 2.
        applyStimulus(1'b0, 6'b000100, NO2, 6'b0, 10'd10, 10'd0, A2, 3'd2, 1'b1, 1'b1, "en_mid0");
        applyStimulus(1'b0, 6'b000100, NO2, 6'b0, 10'd11, 10'd0, A2, 3'd2, 1'b1, 1'b1, "en_mid1");
        applyStimulus(1'b0, 6'b000100, NO2, 6'b0, 10'd12, 10'd0, A2, 3'd2, 1'b1, 1'b1, "en_mid2");
        applyStimulus(1'b0, 6'b000100, NO2, 6'b0, 10'd0,  10'd0, A2, 3'd2, 1'b1, 1'b1, "en_tick_old");
        applyStimulus(1'b0, 6'b000100, NO2, 6'b0, 10'd1,  10'd0, '0, 3'd0, 1'b0, 1'b1, "en_applied");
        checkOutput("phase_tick2", 32'(blinkPhase), 32'd0);
        applyStimulus(1'b0, 6'b000100, ALL, 6'b0, 10'd2,  10'd0, '0, 3'd0, 1'b0, 1'b1, "en_still_off");

        // Held counters: only the first held cycle may reload the shadow enables.
        applyStimulus(1'b0, 6'b001100, NO2, 6'b0, 10'd0, 10'd0, A3, 3'd3, 1'b1, 1'b1, "hold0");
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b0, 6'b001100, ALL, 6'b0, 10'd0, 10'd0, A3, 3'd3, 1'b1, 1'b1, $sformatf("hold%0d", i));
        end
        applyStimulus(1'b0, 6'b001100, ALL, 6'b0, 10'd1, 10'd0, A3, 3'd3, 1'b1, 1'b1, "hold_after");
        checkOutput("phase_after_hold", 32'(blinkPhase), 32'd0);

        // Reset mid-stream: the pixel in flight is flushed, enables return to all ones.
        applyStimulus(1'b0, 6'b001100, ALL, 6'b0, 10'd2, 10'd0, '0, 3'd0, 1'b0, 1'b1, "rst_clears_outputs");
        applyStimulus(1'b1, 6'b001100, ALL, 6'b0, 10'd3, 10'd0, '0, 3'd0, 1'b0, 1'b1, "rst_flush_pipe");
        applyStimulus(1'b0, 6'b001100, NO2, 6'b0, 10'd4, 10'd0, A2, 3'd2, 1'b1, 1'b1, "rst_resume_all_en");
        checkOutput("rst_direct_nb", 32'(notBlank),   32'd0);
        checkOutput("rst_phase",     32'(blinkPhase), 32'd1);
        applyStimulus(1'b0, 6'b000000, NO2, 6'b0, 10'd5, 10'd0, '0, 3'd0, 1'b0, 1'b1, "blank_after_rst");

        // Blink with BLINK_FRAMES=2: layer 0 blinks over layer 1.
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd0, 10'd0, A0, 3'd0, 1'b1, 1'b1, "blk_t1");
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd3, 10'd0, A0, 3'd0, 1'b1, 1'b1, "blk_f1");
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd0, 10'd0, A0, 3'd0, 1'b1, 1'b1, "blk_t2");
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd3, 10'd0, A1, 3'd1, 1'b1, 1'b1, "blk_f2");
        checkOutput("phase_t2", 32'(blinkPhase), 32'd0);
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd0, 10'd0, A1, 3'd1, 1'b1, 1'b1, "blk_t3");
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd3, 10'd0, A1, 3'd1, 1'b1, 1'b1, "blk_f3");
        checkOutput("phase_t3", 32'(blinkPhase), 32'd0);
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd0, 10'd0, A1, 3'd1, 1'b1, 1'b1, "blk_t4");
        applyStimulus(1'b0, 6'b000011, ALL, 6'b000001, 10'd3, 10'd0, A0, 3'd0, 1'b1, 1'b1, "blk_f4");
        checkOutput("phase_t4", 32'(blinkPhase), 32'd1);

        repeat (3) applyStimulus(1'b0, 6'b000000, ALL, 6'b0, 10'd9, 10'd0, '0, '0, 1'b0, 1'b0, "idle");

        pending = 0;
        foreach (sbq[i]) if (sbq[i].check) pending++;
        checkOutput("sb_drain", 32'(pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised per-pixel layer compositor for the VGA path. It takes NUM_LAYERS sprite/tile layer hits and pixel addresses, applies frame-synchronous layer enables and per-layer blinking, and selects the highest-priority visible layer. It outputs a registered `pixel_addr`/`notBlank` pair to the frame-memory read and RGB stage. It replaces the fixed-order, purely combinational stage selector with a pipelined, tear-free, N-channel version.

## Interface
- NUM_LAYERS, 6, number of layer channels; index 0 has the highest priority.
- ADDR_W, 17, width of each layer pixel address.
- BLINK_FRAMES, 16, frames per blink half-period; must be ≥ 1.
- clk  input  1  system clock; one clock domain, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- h_cnt  input  10  horizontal pixel counter from the VGA controller.
- v_cnt  input  10  vertical line counter from the VGA controller.
- layer_hit  input  NUM_LAYERS  bit i = layer i covers the current pixel.
- layer_addr  input  NUM_LAYERS*ADDR_W  layer i address at bits [i*ADDR_W +: ADDR_W].
- layer_en  input  NUM_LAYERS  requested layer enables; takes effect only at frame start.
- blink_mask  input  NUM_LAYERS  bit i = layer i blinks; sampled at frame start.
- pixel_addr  output  ADDR_W  address of the selected layer pixel; 0 when blank.
- notBlank  output  1  a visible layer was selected.
- layer_sel  output  $clog2(NUM_LAYERS)  index of the selected layer; 0 when blank.
- blink_phase  output  1  1 = blinking layers visible.

## Operation
- Frame-start detect:
  - `fs_now = (h_cnt==0 && v_cnt==0)`; a registered copy `fs_d` is kept.
  - `frame_tick = fs_now && !fs_d`, giving exactly one pulse per frame even when counters hold for several clk cycles.
- Shadow registers `en_q` and `blink_q` load from `layer_en` and `blink_mask` on `frame_tick` only. Mid-frame changes are invisible until the next frame.
- Frame counter `fcnt` (width $clog2(BLINK_FRAMES)+1):
  - Increments on each `frame_tick`.
  - When `fcnt == BLINK_FRAMES-1` and `frame_tick`: `fcnt` returns to 0 and `blink_phase` toggles.
- Visible mask: `vis[i] = layer_hit[i] & en_q[i] & (~blink_q[i] | blink_phase)`.
- Stage 1 (registered): `vis` and `layer_addr` are captured.
- Stage 2 (registered): priority encoder over the stage-1 `vis`.
  - The lowest set index i wins: `pixel_addr = addr[i]`, `layer_sel = i`, `notBlank = 1`.
  - If no bit is set: `pixel_addr = 0`, `layer_sel = 0`, `notBlank = 0`.
- Simultaneous `frame_tick` and layer changes: the new `en_q`/`blink_q`/`blink_phase` apply to the `vis` computed in the following cycle. The pixel sampled in the tick cycle uses the old values.

## Timing
- Latency is 2 clk from `layer_hit`/`layer_addr`/`h_cnt` to outputs. Throughput is one pixel per clk, with no stalls.
- Reset values:
  - `pixel_addr` = 0, `notBlank` = 0, `layer_sel` = 0.
  - `blink_phase` = 1, `fcnt` = 0, `fs_d` = 0.
  - `en_q` = all ones, `blink_q` = 0.
  - Pipeline `vis` = 0.
- Reset mid-frame: outputs are 0 from the cycle after `rst` is sampled high. Composition resumes 2 clk after `rst` drops, using `en_q` = all ones until the next frame start.
- `fs_d` resets to 0, so if `h_cnt==v_cnt==0` while `rst` drops, a `frame_tick` fires on the first cycle out of reset.
- BLINK_FRAMES=1: phase toggles on every frame tick.

## Test plan
- Priority: `layer_en` = all ones, frame_tick applied, then `layer_hit=6'b101100` with addr[2]=17'h00123 → 2 clk later `pixel_addr=17'h00123`, `layer_sel=2`, `notBlank=1`.
- Blank: `layer_hit=0` → 2 clk later `notBlank=0`, `pixel_addr=0`, `layer_sel=0`.
- Frame-synchronous enable:
  - Set `layer_en[2]=0` mid-frame with `layer_hit=6'b000100` → output stays layer 2 until `h_cnt=v_cnt=0`.
  - Then `notBlank=0` from the 3rd clk after the tick cycle.
- Held counters: hold `h_cnt=v_cnt=0` for 5 clk → `fcnt` increments by exactly 1.
- Blink, BLINK_FRAMES=2, `blink_mask[0]=1`, `layer_hit=6'b000011`:
  - Frames 0-1 select layer 0.
  - Frames 2-3 select layer 1.
  - Frame 4 selects layer 0 again; `blink_phase` toggles at ticks 2 and 4.
- Reset mid-stream: assert `rst` for 1 clk while `notBlank=1` → next clk all outputs 0, `blink_phase=1`. Output resumes 2 clk after release with all layers enabled.
